sawtooth_ks_ctrl: RTL and testbench
===================================

SAWTOOTH_KS_CTRL -- requirements
Module: sawtooth_ks_ctrl

Interface
REQ-001 SHALL have parameter PRECISION, default 32, operand width of the sawtooth datapath.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, maximum cycles allowed between a sawtooth_tvalid pulse and sawtooth_valid.
REQ-003 SHALL have parameter WARMUP_ITER, default 16, number of transient iterations discarded (used only when the macro is defined).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a keystream run.
- seed_x  in  PRECISION  initial x (IEEE-754 single).
- epsilon_in  in  PRECISION  map parameter.
- num_bytes  in  16  keystream bytes to produce.
- sawtooth_tvalid  out  1  one-cycle operand strobe to the sawtooth block.
- x_out  out  PRECISION  operand x.
- epsilon_out  out  PRECISION  operand epsilon.
- sawtooth_valid  in  1  result strobe from the sawtooth block.
- result_in  in  PRECISION  sawtooth result.
- ks_valid  out  1  keystream byte available.
- ks_ready  in  1  consumer accepts the byte.
- ks_byte  out  8  keystream byte.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, OUTPUT, DONE.
REQ-006 In IDLE, start SHALL latch seed_x into cur_x, epsilon_in and num_bytes, clear err_timeout, and move to ISSUE; if num_bytes==0, it SHALL move to DONE instead.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 ISSUE SHALL assert sawtooth_tvalid for exactly one cycle, with x_out=cur_x and epsilon_out=latched epsilon, then move to WAIT.
REQ-009 At most one sawtooth request SHALL be outstanding at any time.
REQ-010 x_out and epsilon_out SHALL hold stable from the ISSUE cycle until the next ISSUE cycle.
REQ-011 In WAIT, sawtooth_valid SHALL load result_in into cur_x.
- If transients remain: decrement the warmup counter, go to ISSUE.
- Otherwise: register ks_byte = result_in[7:0] XOR result_in[15:8], go to OUTPUT.
REQ-012 sawtooth_valid outside WAIT SHALL be ignored.
REQ-013 In OUTPUT, ks_valid SHALL be 1 and ks_byte SHALL be stable until ks_ready is sampled high.
- On ks_valid&&ks_ready: decrement the remaining count.
- Remaining count reaches 0: go to DONE.
- Otherwise: go to ISSUE.
REQ-014 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 A WAIT lasting TIMEOUT_CYC cycles SHALL set err_timeout and return to IDLE without pulsing done.
REQ-017 sawtooth_valid arriving in the same cycle the timeout expires SHALL take priority, and no error SHALL be flagged.
REQ-018 The byte counter SHALL be 16-bit, so num_bytes=0xFFFF yields exactly 65535 bytes with no wrap.

Reset
REQ-019 Asserting reset at any time SHALL, asynchronously, force state IDLE and drive sawtooth_tvalid, ks_valid, busy, done and err_timeout to 0.
REQ-020 Asserting reset at any time SHALL, asynchronously, drive ks_byte, x_out and epsilon_out to 0 and clear all counters.
REQ-021 Reset mid-run SHALL abandon the run, and a late sawtooth_valid after release SHALL be ignored.

Configuration
REQ-022 With SAWTOOTH_KS_WARMUP_EN defined, the first WARMUP_ITER results of each run SHALL be discarded before the first emitted byte.
REQ-023 Without SAWTOOTH_KS_WARMUP_EN, the warmup counter logic SHALL be absent and the first result SHALL produce the first byte.

Structure
REQ-024 Package sawtooth_ks_pkg SHALL hold the FSM state enum, the default PRECISION, and the byte-extraction bit positions.
REQ-025 The block SHALL be flat with no sub-module; the sawtooth datapath SHALL stay external.

Verification
All scenarios use a stub sawtooth model: fixed 5-cycle latency, result = x+1 (integer).

REQ-026 Start with seed 0x3FE00000, epsilon 0x3D4CCCCD, num_bytes=3, ks_ready=1, macro off -> bytes 0x01, 0x02, 0x03, three sawtooth_tvalid pulses, then one done pulse.
REQ-027 Same stimulus with the macro on (WARMUP_ITER=16) -> 19 sawtooth_tvalid pulses and bytes 0x11, 0x12, 0x13.
REQ-028 ks_ready held low for 10 cycles during the first byte -> ks_valid held and ks_byte stable at 0x01, and no new sawtooth_tvalid until the byte is accepted.
REQ-029 Stub never responds -> err_timeout=1 exactly TIMEOUT_CYC cycles after the pulse, state IDLE, done never pulses.
REQ-030 num_bytes=0 -> done pulses two cycles after start, with no sawtooth_tvalid.
REQ-031 reset asserted in WAIT, stub response arrives after release -> outputs stay at reset values, with no ks_valid.

Source files
------------

// File: rtl/sawtooth_ks_pkg.sv
// sawtooth_ks_pkg: shared state encoding, default width and keystream byte bit positions.
// Revision: 1.0
`default_nettype none

package sawtooth_ks_pkg;

  localparam int DEFAULT_PRECISION = 32;

  // Keystream byte is the XOR of these two result bytes
  localparam int KS_LO_LSB = 0;
  localparam int KS_HI_LSB = 8;
  localparam int KS_W      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [KS_W-1:0] extract_ks(input logic [15:0] r);
    return r[KS_LO_LSB +: KS_W] ^ r[KS_HI_LSB +: KS_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sawtooth_ks_ctrl.sv
// sawtooth_ks_ctrl: sequences an external sawtooth map and emits keystream bytes.
// Optional transient discard enabled by SAWTOOTH_KS_WARMUP_EN. Revision: 1.0
`default_nettype none

module sawtooth_ks_ctrl
  import sawtooth_ks_pkg::*;
#(
  parameter int PRECISION   = DEFAULT_PRECISION,
  parameter int TIMEOUT_CYC = 64,
  parameter int WARMUP_ITER = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PRECISION-1:0] seed_x,
  input  logic [PRECISION-1:0] epsilon_in,
  input  logic [15:0]          num_bytes,
  output logic                 sawtooth_tvalid,
  output logic [PRECISION-1:0] x_out,
  output logic [PRECISION-1:0] epsilon_out,
  input  logic                 sawtooth_valid,
  input  logic [PRECISION-1:0] result_in,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [7:0]           ks_byte,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t                 state, state_nxt;
  logic [PRECISION-1:0]   cur_x, cur_x_nxt;
  logic [PRECISION-1:0]   eps_q, eps_nxt;
  logic [15:0]            remaining, remaining_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [7:0]             ks_byte_nxt;
  logic                   err_nxt;
  logic                   done_nxt;

`ifdef SAWTOOTH_KS_WARMUP_EN
  localparam int WW = (WARMUP_ITER < 1) ? 1 : $clog2(WARMUP_ITER + 1);
  logic [WW-1:0]          warm, warm_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_x       <= '0;
      eps_q       <= '0;
      remaining   <= '0;
      timer       <= '0;
      ks_byte     <= '0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
      x_out       <= '0;
      epsilon_out <= '0;
`ifdef SAWTOOTH_KS_WARMUP_EN
      warm        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cur_x       <= cur_x_nxt;
      eps_q       <= eps_nxt;
      remaining   <= remaining_nxt;
      timer       <= timer_nxt;
      ks_byte     <= ks_byte_nxt;
      err_timeout <= err_nxt;
      done        <= done_nxt;
`ifdef SAWTOOTH_KS_WARMUP_EN
      warm        <= warm_nxt;
`endif
      // Operands are captured on entry to ISSUE so they stay put until the next request
      if (state_nxt == ISSUE) begin
        x_out       <= cur_x_nxt;
        epsilon_out <= eps_nxt;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_x_nxt     = cur_x;
    eps_nxt       = eps_q;
    remaining_nxt = remaining;
    timer_nxt     = timer;
    ks_byte_nxt   = ks_byte;
    err_nxt       = err_timeout;
    done_nxt      = 1'b0;
`ifdef SAWTOOTH_KS_WARMUP_EN
    warm_nxt      = warm;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          cur_x_nxt     = seed_x;
          eps_nxt       = epsilon_in;
          remaining_nxt = num_bytes;
          err_nxt       = 1'b0;
`ifdef SAWTOOTH_KS_WARMUP_EN
          warm_nxt      = WW'(WARMUP_ITER);
`endif
          state_nxt     = (num_bytes == 16'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A result in the final WAIT cycle beats the timeout
        if (sawtooth_valid) begin
          cur_x_nxt = result_in;
`ifdef SAWTOOTH_KS_WARMUP_EN
          if (warm != '0) begin
            warm_nxt  = warm - 1'b1;
            state_nxt = ISSUE;
          end else begin
            ks_byte_nxt = extract_ks(result_in[15:0]);
            state_nxt   = OUTPUT;
          end
`else
          ks_byte_nxt = extract_ks(result_in[15:0]);
          state_nxt   = OUTPUT;
`endif
        end else if (timer == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      OUTPUT: begin
        if (ks_ready) begin
          remaining_nxt = remaining - 16'd1;
          state_nxt     = (remaining == 16'd1) ? DONE : ISSUE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sawtooth_tvalid = (state == ISSUE);
  assign ks_valid        = (state == OUTPUT);
  assign busy            = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sawtooth_ks_ctrl.sv
// tb_sawtooth_ks_ctrl: directed bench for sawtooth_ks_ctrl with a fixed-latency x+1 stub.
// Revision: 1.0
`default_nettype none

module tb_sawtooth_ks_ctrl;

  localparam int P = 32;
  localparam int T = 64;
`ifdef SAWTOOTH_KS_WARMUP_EN
  localparam int WU = 16;
`else
  localparam int WU = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [P-1:0]  seed_x;
  logic [P-1:0]  epsilon_in;
  logic [15:0]   num_bytes;
  logic          sawtooth_tvalid;
  logic [P-1:0]  x_out;
  logic [P-1:0]  epsilon_out;
  logic          sawtooth_valid;
  logic [P-1:0]  result_in;
  logic          ks_valid;
  logic          ks_ready;
  logic [7:0]    ks_byte;
  logic          busy;
  logic          done;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int dones    = 0;
  int stub_lat = 5;
  bit stub_en  = 1'b1;

  logic [7:0] got [0:7];
  int         got_n;
  bit         timed_out;

  sawtooth_ks_ctrl #(.PRECISION(P), .TIMEOUT_CYC(T), .WARMUP_ITER(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_x(seed_x),
    .epsilon_in(epsilon_in), .num_bytes(num_bytes),
    .sawtooth_tvalid(sawtooth_tvalid), .x_out(x_out), .epsilon_out(epsilon_out),
    .sawtooth_valid(sawtooth_valid), .result_in(result_in),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_byte(ks_byte),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Stub sawtooth block: result = x+1, valid stub_lat cycles after the strobe
  initial begin
    int pend;
    logic [P-1:0] sx;
    pend = 0;
    sx = '0;
    sawtooth_valid = 1'b0;
    result_in = '0;
    forever begin
      @(negedge clk);
      sawtooth_valid = 1'b0;
      if (done) dones++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          sawtooth_valid = 1'b1;
          result_in = sx + 1;
        end
      end
      if (sawtooth_tvalid) begin
        pulses++;
        if (stub_en) begin
          sx = x_out;
          pend = stub_lat;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input int max_cyc);
    got_n = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ks_valid && ks_ready && got_n < 8) begin
        got[got_n] = ks_byte;
        got_n++;
      end
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_start(input logic [P-1:0] s, input logic [P-1:0] e, input logic [15:0] n);
    seed_x = s;
    epsilon_in = e;
    num_bytes = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int p0;
    int d0;
    logic [7:0] b0;
    reset = 1'b1;
    start = 1'b0;
    seed_x = '0;
    epsilon_in = '0;
    num_bytes = '0;
    ks_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_tvalid", {31'b0, sawtooth_tvalid}, 32'd0);
    check("rst_ksvalid", {31'b0, ks_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err_timeout}, 32'd0);
    check("rst_xout", x_out, 32'd0);
    check("rst_epsout", epsilon_out, 32'd0);
    check("rst_ksbyte", {24'b0, ks_byte}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic three-byte run
    p0 = pulses;
    d0 = dones;
    do_start(32'h3FE00000, 32'h3D4CCCCD, 16'd3);
    check("t1_first_tvalid", {31'b0, sawtooth_tvalid}, 32'd1);
    check("t1_xout", x_out, 32'h3FE00000);
    check("t1_epsout", epsilon_out, 32'h3D4CCCCD);
    collect(3000);
    check("t1_timeout", {31'b0, timed_out}, 32'd0);
    check("t1_nbytes", got_n, 32'd3);
    check("t1_byte0", {24'b0, got[0]}, 32'(8'h01 + WU));
    check("t1_byte1", {24'b0, got[1]}, 32'(8'h02 + WU));
    check("t1_byte2", {24'b0, got[2]}, 32'(8'h03 + WU));
    @(negedge clk);
    check("t1_pulses", pulses - p0, 32'(3 + WU));
    check("t1_dones", dones - d0, 32'd1);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_done_single", {31'b0, done}, 32'd0);

    // Back-pressure on the first byte, with a stray start while busy
    ks_ready = 1'b0;
    p0 = pulses;
    d0 = dones;
    do_start(32'h3FE00000, 32'h3D4CCCCD, 16'd2);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (ks_valid) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("t2_wait_ksvalid", {31'b0, timed_out}, 32'd0);
    b0 = 8'(8'h01 + WU);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        num_bytes = 16'd0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("t2_hold_valid", {31'b0, ks_valid}, 32'd1);
      check("t2_hold_byte", {24'b0, ks_byte}, {24'b0, b0});
    end
    start = 1'b0;
    check("t2_no_new_pulse", pulses - p0, 32'(1 + WU));
    check("t2_no_done", dones - d0, 32'd0);
    ks_ready = 1'b1;
    collect(3000);
    check("t2_timeout", {31'b0, timed_out}, 32'd0);
    check("t2_nbytes_rest", got_n, 32'd1);
    check("t2_byte1", {24'b0, got[0]}, 32'(8'h02 + WU));
    @(negedge clk);

    // Zero-length run: done two cycles after start, no strobe
    p0 = pulses;
    d0 = dones;
    num_bytes = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_done_early", {31'b0, done}, 32'd0);
    check("t3_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("t3_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("t3_done_drop", {31'b0, done}, 32'd0);
    check("t3_no_pulse", pulses - p0, 32'd0);
    check("t3_dones", dones - d0, 32'd1);

    // Silent stub: timeout exactly after TIMEOUT_CYC WAIT cycles
    stub_en = 1'b0;
    d0 = dones;
    do_start(32'h3FE00000, 32'h3D4CCCCD, 16'd1);
    check("t4_tvalid", {31'b0, sawtooth_tvalid}, 32'd1);
    repeat (T) @(negedge clk);
    check("t4_err_early", {31'b0, err_timeout}, 32'd0);
    check("t4_busy_early", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("t4_err", {31'b0, err_timeout}, 32'd1);
    check("t4_idle", {31'b0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("t4_no_done", dones - d0, 32'd0);
    check("t4_err_sticky", {31'b0, err_timeout}, 32'd1);
    stub_en = 1'b1;

    // Result in the very last WAIT cycle wins over the timeout
    stub_lat = T;
    do_start(32'h3FE00000, 32'h3D4CCCCD, 16'd1);
    check("t5_err_cleared", {31'b0, err_timeout}, 32'd0);
    collect(4000);
    check("t5_timeout", {31'b0, timed_out}, 32'd0);
    check("t5_nbytes", got_n, 32'd1);
    check("t5_byte", {24'b0, got[0]}, 32'(8'h01 + WU));
    check("t5_no_err", {31'b0, err_timeout}, 32'd0);
    stub_lat = 5;
    @(negedge clk);

    // Reset in WAIT; late stub response must be ignored
    d0 = dones;
    do_start(32'h3FE00000, 32'h3D4CCCCD, 16'd1);
    repeat (2) @(negedge clk);
    check("t6_in_wait", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_xout", x_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit saw_valid;
      bit saw_busy;
      saw_valid = 1'b0;
      saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ks_valid) saw_valid = 1'b1;
        if (busy) saw_busy = 1'b1;
      end
      check("t6_no_ksvalid", {31'b0, saw_valid}, 32'd0);
      check("t6_no_busy", {31'b0, saw_busy}, 32'd0);
    end
    check("t6_no_done", dones - d0, 32'd0);
    check("t6_ksbyte", {24'b0, ks_byte}, 32'd0);
    check("t6_epsout", epsilon_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
